// File: rtl/watch_pkg.sv
// Shared types and widths for the watch alarm stage.
package watch_pkg;

    // Widths of the hour (mod 24) and minute/second (mod 60) fields
    localparam int unsigned HOUR_W = $clog2(24);
    localparam int unsigned MIN_W  = $clog2(60);

    // Alarm FSM state encoding
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRinging = 2'd1,
        StSnooze  = 2'd2
    } alarm_state_e;

endpackage

// File: rtl/tick_counter.sv
// Modulo-N counter with enable, synchronous clear and a wrap pulse.
module tick_counter #(
    parameter int unsigned N = 60
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    output logic [$clog2(N)-1:0] count,
    output logic                 wrap
);

    localparam int unsigned W = $clog2(N);
    localparam logic [W-1:0] Last = W'(N - 1);

    logic [W-1:0] count_q, count_d;

    // wrap flags the enabled step that takes the count from N-1 back to 0
    assign wrap  = en && (count_q == Last);
    assign count = count_q;

    // Next count: clear wins over counting
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (wrap) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/watch_alarm.sv
// Alarm stage: stored alarm time, match edge detect, RINGING/SNOOZE FSM and beep gating.
module watch_alarm
    import watch_pkg::*;
#(
    parameter int unsigned BIT_100HZ  = 100,
    parameter int unsigned SECOND_60  = 60,
    parameter int unsigned HOUR       = 24,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned BEEP_ON    = 50,
    parameter int unsigned ALARM_H0   = 7,
    parameter int unsigned ALARM_M0   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [HOUR_W-1:0] hour,
    input  logic [MIN_W-1:0]  min,
    input  logic [MIN_W-1:0]  sec,
    input  logic              tick_1s,
    input  logic              tick_100hz,
    input  logic              alarm_en,
    input  logic              set_mode,
    input  logic              btn_hour,
    input  logic              btn_min,
    input  logic              btn_stop,
    input  logic              btn_snooze,
    output logic [HOUR_W-1:0] alarm_hour,
    output logic [MIN_W-1:0]  alarm_min,
    output logic              ringing,
    output logic              snoozing,
    output logic              beep
);

    logic [HOUR_W-1:0] alarm_hour_q;
    logic [MIN_W-1:0]  alarm_min_q;
    logic              match, match_q, trigger;
    alarm_state_e      state_q, state_d;

    logic ring_wrap, snz_wrap;
    logic [$clog2(BIT_100HZ)-1:0]  beep_cnt;
    logic [$clog2(RING_SEC)-1:0]   unused_ring_cnt;
    logic [$clog2(SNOOZE_SEC)-1:0] unused_snz_cnt;
    logic                          unused_beep_wrap;

    // Alarm time registers; edits wrap independently (no minute-to-hour carry)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_hour_q <= HOUR_W'(ALARM_H0);
            alarm_min_q  <= MIN_W'(ALARM_M0);
        end else if (set_mode) begin
            if (btn_hour) begin
                alarm_hour_q <= (alarm_hour_q == HOUR_W'(HOUR - 1)) ? '0 : alarm_hour_q + 1'b1;
            end
            if (btn_min) begin
                alarm_min_q <= (alarm_min_q == MIN_W'(SECOND_60 - 1)) ? '0 : alarm_min_q + 1'b1;
            end
        end
    end

    // Compare against the registered alarm so a same-cycle edit does not affect the trigger
    assign match   = (hour == alarm_hour_q) && (min == alarm_min_q) && (sec == '0);
    assign trigger = match && !match_q && alarm_en && !set_mode;

    // Match history for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match;
        end
    end

    // Counters are held at zero outside their state, so entry always starts from zero
    tick_counter #(.N(RING_SEC)) u_ring_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == StRinging && tick_1s),
        .clr   (state_q != StRinging),
        .count (unused_ring_cnt),
        .wrap  (ring_wrap)
    );

    tick_counter #(.N(SNOOZE_SEC)) u_snz_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == StSnooze && tick_1s),
        .clr   (state_q != StSnooze),
        .count (unused_snz_cnt),
        .wrap  (snz_wrap)
    );

    tick_counter #(.N(BIT_100HZ)) u_beep_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == StRinging && tick_100hz),
        .clr   (state_q != StRinging),
        .count (beep_cnt),
        .wrap  (unused_beep_wrap)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: alarm_en low > stop > snooze > counter expiry
    always_comb begin
        state_d = state_q;
        if (!alarm_en) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (trigger) state_d = StRinging;
                end
                StRinging: begin
                    if (btn_stop)        state_d = StIdle;
                    else if (btn_snooze) state_d = StSnooze;
                    else if (ring_wrap)  state_d = StIdle;
                end
                StSnooze: begin
                    if (btn_stop)      state_d = StIdle;
                    else if (snz_wrap) state_d = StRinging;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs decoded from registers only
    always_comb begin
        ringing    = (state_q == StRinging);
        snoozing   = (state_q == StSnooze);
        beep       = ringing && (32'(beep_cnt) < BEEP_ON);
        alarm_hour = alarm_hour_q;
        alarm_min  = alarm_min_q;
    end

endmodule
